// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the ALU command sequencer: opcodes, FSM states,
// the idle "hold" drive that leaves the external accumulator untouched, and the FIFO entry layout.
package alu_seq_pkg;

    typedef enum logic [3:0] {
        OP_ADD     = 4'h0,
        OP_SUB     = 4'h1,
        OP_AND     = 4'h2,
        OP_OR      = 4'h3,
        OP_ACC_ADD = 4'h4,
        OP_ACC_SUB = 4'h5,
        OP_ACC_MUL = 4'h6,
        OP_XOR     = 4'h7,
        OP_CMP_EQ  = 4'h8,
        OP_CMP_LT  = 4'h9,
        OP_SHL     = 4'hA,
        OP_SHR     = 4'hB,
        OP_NOT     = 4'hC,
        OP_PASS_A  = 4'hD,
        OP_PASS_B  = 4'hE,
        OP_MUL     = 4'hF
    } alu_op_e;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WAIT,
        ST_RESP,
        ST_CLR,
        ST_CLR_WAIT
    } seq_state_e;

    localparam int DATA_W = 8;
    localparam int SEL_W  = 4;
    localparam int CMD_W  = SEL_W + 2 * DATA_W;

    // Acc + 0 keeps the accumulator value; ADD 0,0 forces it to zero.
    localparam logic [SEL_W-1:0]  HOLD_SEL = SEL_W'(OP_ACC_ADD);
    localparam logic [DATA_W-1:0] HOLD_A   = '0;
    localparam logic [DATA_W-1:0] HOLD_B   = '0;
    localparam logic [SEL_W-1:0]  CLR_SEL  = SEL_W'(OP_ADD);

    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [DATA_W-1:0] a;
        logic [DATA_W-1:0] b;
    } cmd_t;

    function automatic cmd_t pack_cmd(input logic [SEL_W-1:0] sel,
                                      input logic [DATA_W-1:0] a,
                                      input logic [DATA_W-1:0] b);
        cmd_t c;
        c.sel = sel;
        c.a   = a;
        c.b   = b;
        return c;
    endfunction

endpackage

// File: rtl/alu_seq_fifo.sv
// Command queue for the ALU sequencer: DEPTH entries (power of two), synchronous push/pop,
// head visible combinationally on pop_data. Push when full and pop when empty are ignored.
module alu_seq_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 20
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Pointers are exactly log2(DEPTH) wide, so incrementing wraps modulo DEPTH for free.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Queues ALU commands and issues them one at a time to an external registered ALU/accumulator.
// Define ALU_SEQ_CLR_ON_RESET_EN to zero the accumulator with a short CLR sequence after reset.
module alu_sequencer
    import alu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [DATA_W-1:0] cmd_a,
    input  logic [DATA_W-1:0] cmd_b,
    input  logic [SEL_W-1:0]  cmd_sel,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [SEL_W-1:0]  alu_sel,
    input  logic [DATA_W-1:0] alu_out,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_data,
    output logic [SEL_W-1:0]  rsp_sel,
    output logic              busy
);

`ifdef ALU_SEQ_CLR_ON_RESET_EN
    localparam logic CLR_ON_RESET = 1'b1;
`else
    localparam logic CLR_ON_RESET = 1'b0;
`endif

    seq_state_e        state_q, state_d;
    logic [DATA_W-1:0] alu_a_q, alu_a_d;
    logic [DATA_W-1:0] alu_b_q, alu_b_d;
    logic [SEL_W-1:0]  alu_sel_q, alu_sel_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
    logic [SEL_W-1:0]  rsp_sel_q, rsp_sel_d;
    logic              clr_pending_q, clr_pending_d;

    logic              fifo_push;
    logic              fifo_pop;
    logic              fifo_full;
    logic              fifo_empty;
    logic [CMD_W-1:0]  fifo_head;
    cmd_t              head;
    logic              in_clr;

    assign in_clr    = (state_q == ST_CLR) || (state_q == ST_CLR_WAIT);
    assign cmd_ready = !fifo_full && !in_clr;
    assign fifo_push = cmd_valid && cmd_ready;
    assign head      = cmd_t'(fifo_head);
    assign busy      = !fifo_empty || (state_q != ST_IDLE);

    alu_seq_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (CMD_W)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (pack_cmd(cmd_sel, cmd_a, cmd_b)),
        .pop       (fifo_pop),
        .pop_data  (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // alu_* default to the hold drive every cycle; only the pop and CLR transitions override it.
    always_comb begin
        state_d       = state_q;
        alu_a_d       = HOLD_A;
        alu_b_d       = HOLD_B;
        alu_sel_d     = HOLD_SEL;
        rsp_valid_d   = rsp_valid_q;
        rsp_data_d    = rsp_data_q;
        rsp_sel_d     = rsp_sel_q;
        clr_pending_d = clr_pending_q;
        fifo_pop      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (clr_pending_q) begin
                    clr_pending_d = 1'b0;
                    alu_sel_d     = CLR_SEL;
                    state_d       = ST_CLR;
                end else if (!fifo_empty) begin
                    fifo_pop  = 1'b1;
                    alu_a_d   = head.a;
                    alu_b_d   = head.b;
                    alu_sel_d = head.sel;
                    rsp_sel_d = head.sel;
                    state_d   = ST_EXEC;
                end
            end
            ST_EXEC: begin
                state_d = ST_WAIT;
            end
            // The ALU registered the issued op at the end of EXEC, so alu_out now holds the result.
            ST_WAIT: begin
                rsp_data_d  = alu_out;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            ST_CLR: begin
                state_d = ST_CLR_WAIT;
            end
            ST_CLR_WAIT: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            alu_a_q       <= HOLD_A;
            alu_b_q       <= HOLD_B;
            alu_sel_q     <= HOLD_SEL;
            rsp_valid_q   <= 1'b0;
            rsp_data_q    <= '0;
            rsp_sel_q     <= '0;
            clr_pending_q <= CLR_ON_RESET;
        end else begin
            state_q       <= state_d;
            alu_a_q       <= alu_a_d;
            alu_b_q       <= alu_b_d;
            alu_sel_q     <= alu_sel_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_data_q    <= rsp_data_d;
            rsp_sel_q     <= rsp_sel_d;
            clr_pending_q <= clr_pending_d;
        end
    end

    assign alu_a     = alu_a_q;
    assign alu_b     = alu_b_q;
    assign alu_sel   = alu_sel_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_sel   = rsp_sel_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: a behavioural registered ALU plus an in-order
// result scoreboard. Honours ALU_SEQ_CLR_ON_RESET_EN when the build defines it.
module tb_alu_sequencer;
    import alu_seq_pkg::*;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       cmd_valid = 1'b0;
    logic       cmd_ready;
    logic [7:0] cmd_a = '0;
    logic [7:0] cmd_b = '0;
    logic [3:0] cmd_sel = '0;
    logic [7:0] alu_a;
    logic [7:0] alu_b;
    logic [3:0] alu_sel;
    logic [7:0] alu_out;
    logic       rsp_valid;
    logic       rsp_ready = 1'b0;
    logic [7:0] rsp_data;
    logic [3:0] rsp_sel;
    logic       busy;

    int checks = 0;
    int passes = 0;

    logic [7:0]  model_acc = '0;
    bit          acc_known = 1'b0;
    logic [11:0] exp_q[$];

    always #5 clk = ~clk;

    alu_sequencer #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .cmd_valid (cmd_valid),
        .cmd_ready (cmd_ready),
        .cmd_a     (cmd_a),
        .cmd_b     (cmd_b),
        .cmd_sel   (cmd_sel),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_sel   (alu_sel),
        .alu_out   (alu_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_sel   (rsp_sel),
        .busy      (busy)
    );

    // Opcode semantics as plain 8-bit arithmetic.
    function automatic logic [7:0] model_op(input logic [3:0] op, input logic [7:0] a,
                                            input logic [7:0] b, input logic [7:0] acc);
        case (op)
            4'h0: return a + b;
            4'h1: return a - b;
            4'h2: return a & b;
            4'h3: return a | b;
            4'h4: return acc + a;
            4'h5: return acc - a;
            4'h6: return acc * a;
            4'h7: return a ^ b;
            4'h8: return (a == b) ? 8'd1 : 8'd0;
            4'h9: return (a < b) ? 8'd1 : 8'd0;
            4'hA: return a << b[2:0];
            4'hB: return a >> b[2:0];
            4'hC: return ~a;
            4'hD: return a;
            4'hE: return b;
            default: return a * b;
        endcase
    endfunction

    // External registered ALU whose result register is the accumulator.
    logic [7:0] acc_reg;
    always_ff @(posedge clk) acc_reg <= model_op(alu_sel, alu_a, alu_b, acc_reg);
    assign alu_out = acc_reg;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [3:0] rand_op();
        logic [3:0] op;
        op = 4'($urandom_range(0, 15));
        if (!acc_known && (op == 4'h4 || op == 4'h5 || op == 4'h6)) op = 4'h0;
        return op;
    endfunction

    function automatic void model_accept(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] res;
        res = model_op(op, a, b, model_acc);
        model_acc = res;
        acc_known = 1'b1;
        exp_q.push_back({op, res});
    endfunction

    task automatic push_cmd(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
        int n = 0;
        while (cmd_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        if (cmd_ready !== 1'b1) begin
            checks++;
            $display("[TB] FAIL push_timeout: cmd_ready=%b, wanted 1 within 40 cycles", cmd_ready);
            return;
        end
        cmd_sel   = op;
        cmd_a     = a;
        cmd_b     = b;
        cmd_valid = 1'b1;
        tick();
        cmd_valid = 1'b0;
        model_accept(op, a, b);
    endtask

    task automatic pop_rsp(input string tag, input int stall);
        int n = 0;
        logic [11:0] exp;
        logic [11:0] first;
        while (rsp_valid !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        checks++;
        if (rsp_valid !== 1'b1) begin
            $display("[TB] FAIL %s rsp_timeout: rsp_valid=%b, wanted 1", tag, rsp_valid);
            return;
        end
        passes++;
        exp = (exp_q.size() > 0) ? exp_q.pop_front() : 12'hxxx;
        first = {rsp_sel, rsp_data};
        repeat (stall) tick();
        if (stall > 0) begin
            checks++;
            if (first !== exp)
                $display("[TB] FAIL %s first_rsp: got sel=%h data=%0d, wanted sel=%h data=%0d",
                         tag, first[11:8], first[7:0], exp[11:8], exp[7:0]);
            else passes++;
        end
        checks++;
        if ({rsp_valid, rsp_sel, rsp_data} !== {1'b1, exp})
            $display("[TB] FAIL %s rsp: got valid=%b sel=%h data=%0d, wanted valid=1 sel=%h data=%0d",
                     tag, rsp_valid, rsp_sel, rsp_data, exp[11:8], exp[7:0]);
        else passes++;
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++;
        if (rsp_valid !== 1'b0)
            $display("[TB] FAIL %s rsp_drop: rsp_valid=%b, wanted 0", tag, rsp_valid);
        else passes++;
    endtask

    task automatic apply_reset(input string tag);
        cmd_valid = 1'b0;
        rsp_ready = 1'b0;
        rst = 1'b1;
        #1;
        checks++;
        if ({cmd_ready, rsp_valid, busy} !== 3'b100)
            $display("[TB] FAIL %s reset_flags: got ready/valid/busy=%b, wanted 100",
                     tag, {cmd_ready, rsp_valid, busy});
        else passes++;
        checks++;
        if ({rsp_sel, rsp_data} !== 12'h000)
            $display("[TB] FAIL %s reset_rsp: got sel=%h data=%h, wanted 0/0", tag, rsp_sel, rsp_data);
        else passes++;
        checks++;
        if ({alu_sel, alu_a, alu_b} !== {4'b0100, 8'h00, 8'h00})
            $display("[TB] FAIL %s reset_alu: got sel=%b a=%h b=%h, wanted 0100/00/00",
                     tag, alu_sel, alu_a, alu_b);
        else passes++;
        tick();
        tick();
        rst = 1'b0;
        exp_q.delete();
        tick();
`ifdef ALU_SEQ_CLR_ON_RESET_EN
        checks++;
        if ({cmd_ready, busy, alu_sel, alu_a, alu_b} !== {1'b0, 1'b1, 4'b0000, 16'h0000})
            $display("[TB] FAIL %s clr_cycle: got ready=%b busy=%b sel=%b a=%h b=%h, wanted 0/1/0000/00/00",
                     tag, cmd_ready, busy, alu_sel, alu_a, alu_b);
        else passes++;
        tick();
        checks++;
        if ({cmd_ready, busy, rsp_valid, alu_sel} !== {1'b0, 1'b1, 1'b0, 4'b0100})
            $display("[TB] FAIL %s clr_wait: got ready=%b busy=%b valid=%b sel=%b, wanted 0/1/0/0100",
                     tag, cmd_ready, busy, rsp_valid, alu_sel);
        else passes++;
        tick();
        model_acc = 8'h00;
        acc_known = 1'b1;
`else
        acc_known = 1'b0;
`endif
        checks++;
        if ({cmd_ready, busy, rsp_valid, alu_sel} !== {1'b1, 1'b0, 1'b0, 4'b0100})
            $display("[TB] FAIL %s post_reset_idle: got ready=%b busy=%b valid=%b sel=%b, wanted 1/0/0/0100",
                     tag, cmd_ready, busy, rsp_valid, alu_sel);
        else passes++;
    endtask

    task automatic test_reset();
        apply_reset("reset");
    endtask

`ifdef ALU_SEQ_CLR_ON_RESET_EN
    task automatic test_clear();
        push_cmd(4'h4, 8'd9, 8'd0);
        pop_rsp("clr_acc_add9", 0);
    endtask
`endif

    task automatic test_latency();
        push_cmd(4'h0, 8'd5, 8'd3);
        tick();
        checks++;
        if ({alu_sel, alu_a, alu_b, rsp_valid} !== {4'h0, 8'd5, 8'd3, 1'b0})
            $display("[TB] FAIL issue_drive: got sel=%h a=%0d b=%0d valid=%b, wanted 0/5/3/0",
                     alu_sel, alu_a, alu_b, rsp_valid);
        else passes++;
        tick();
        checks++;
        if ({alu_sel, alu_a, alu_b, rsp_valid} !== {4'b0100, 16'h0000, 1'b0})
            $display("[TB] FAIL hold_drive: got sel=%b a=%0d b=%0d valid=%b, wanted 0100/0/0/0",
                     alu_sel, alu_a, alu_b, rsp_valid);
        else passes++;
        tick();
        checks++;
        if ({rsp_valid, rsp_data, rsp_sel} !== {1'b1, 8'd8, 4'h0})
            $display("[TB] FAIL latency_add53: got valid=%b data=%0d sel=%h, wanted 1/8/0",
                     rsp_valid, rsp_data, rsp_sel);
        else passes++;
        pop_rsp("add53", 0);
    endtask

    task automatic test_accumulate();
        push_cmd(4'h0, 8'd2, 8'd3);
        pop_rsp("acc_add23", 10);
        push_cmd(4'h4, 8'd4, 8'($urandom_range(0, 255)));
        pop_rsp("acc_plus4", 10);
        push_cmd(4'h6, 8'd2, 8'($urandom_range(0, 255)));
        pop_rsp("acc_times2", 10);
        checks++;
        if (model_acc !== 8'd18)
            $display("[TB] FAIL acc_chain_model: got %0d, wanted 18", model_acc);
        else passes++;
    endtask

    task automatic test_back_to_back();
        int accepted = 0;
        logic [3:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic had_ready;
        rsp_ready = 1'b0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            if (accepted < 6 && !cmd_valid) begin
                op = rand_op();
                a  = 8'($urandom_range(0, 255));
                b  = 8'($urandom_range(0, 255));
                cmd_sel   = op;
                cmd_a     = a;
                cmd_b     = b;
                cmd_valid = 1'b1;
            end
            had_ready = cmd_ready;
            tick();
            if (cmd_valid && had_ready) begin
                model_accept(op, a, b);
                accepted++;
                cmd_valid = 1'b0;
            end
        end
        checks++;
        if (accepted !== 5)
            $display("[TB] FAIL b2b_accepted: got %0d, wanted 5", accepted);
        else passes++;
        checks++;
        if ({cmd_ready, busy} !== 2'b01)
            $display("[TB] FAIL b2b_full: got ready=%b busy=%b, wanted 0/1", cmd_ready, busy);
        else passes++;
        cmd_valid = 1'b0;
        for (int i = 0; i < 5; i++) pop_rsp($sformatf("b2b_rsp%0d", i), 0);
        push_cmd(op, a, b);
        pop_rsp("b2b_sixth", 0);
    endtask

    task automatic test_reset_mid();
        bit seen = 1'b0;
        push_cmd(4'h8, 8'd7, 8'd7);
        push_cmd(4'h0, 8'd20, 8'd22);
        tick();
        checks++;
        if ({rsp_valid, busy} !== 2'b01)
            $display("[TB] FAIL mid_pre_reset: got valid=%b busy=%b, wanted 0/1", rsp_valid, busy);
        else passes++;
        apply_reset("mid_reset");
        for (int i = 0; i < 8; i++) begin
            if (rsp_valid !== 1'b0) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen)
            $display("[TB] FAIL mid_no_rsp: response after reset, wanted none");
        else passes++;
        push_cmd(4'h0, 8'd1, 8'd1);
        pop_rsp("mid_add11", 0);
    endtask

    task automatic test_random();
        int n;
        for (int it = 0; it < 20; it++) begin
            n = $urandom_range(1, 3);
            for (int k = 0; k < n; k++)
                push_cmd(rand_op(), 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            for (int k = 0; k < n; k++)
                pop_rsp($sformatf("rand%0d_%0d", it, k), $urandom_range(0, 3));
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        tick();
        test_reset();
`ifdef ALU_SEQ_CLR_ON_RESET_EN
        test_clear();
`endif
        test_latency();
        test_accumulate();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
ALU_SEQUENCER -- requirements
Module: alu_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have ports cmd_valid input 1, cmd_ready output 1: command handshake.
REQ-005 SHALL have ports cmd_a input 8, cmd_b input 8, cmd_sel input 4: operands and 4-bit ALU opcode.
REQ-006 SHALL have ports alu_a output 8, alu_b output 8, alu_sel output 4: registered drive to the ALU A, B, select.
REQ-007 SHALL have port alu_out  input  8  registered ALU result.
REQ-008 SHALL have ports rsp_valid output 1, rsp_ready input 1, rsp_data output 8, rsp_sel output 4: result handshake, echoing the opcode.
REQ-009 SHALL have port busy  output  1  high when the FIFO is non-empty or state is not IDLE.

Function
REQ-010 SHALL accept a command when cmd_valid && cmd_ready; cmd_ready = FIFO not full.
REQ-011 SHALL allow push and pop in the same cycle; a full FIFO with a simultaneous pop still refuses the push (cmd_ready depends on count only).
REQ-012 SHALL use FSM states IDLE, EXEC, WAIT, RESP (plus CLR, see REQ-024).
REQ-013 IDLE with FIFO non-empty: at the next edge SHALL pop the head, load alu_a/alu_b/alu_sel from it, latch rsp_sel, and go to EXEC.
REQ-014 EXEC: at the next edge SHALL drive the hold pattern (alu_sel=4'b0100, alu_a=0, alu_b=0) and go to WAIT.
REQ-015 WAIT: at the next edge SHALL register rsp_data<=alu_out, set rsp_valid=1, and go to RESP; issue-to-rsp_valid latency is exactly 3 cycles.
REQ-016 RESP: SHALL hold rsp_data/rsp_sel stable while rsp_valid && !rsp_ready; on rsp_ready SHALL clear rsp_valid at the next edge and go to IDLE.
REQ-017 Outside the EXEC-issued cycle, alu_* SHALL always carry the hold pattern, so the accumulator (Acc+0) is preserved indefinitely.
REQ-018 SHALL process one command at a time; there is no issue until the prior response has been accepted.
REQ-019 FIFO pointers SHALL wrap modulo DEPTH; count width SHALL be log2(DEPTH)+1.

Reset
REQ-020 Asserting rst SHALL force: state IDLE, FIFO empty, cmd_ready=1, rsp_valid=0, rsp_data=0, rsp_sel=0, busy=0, alu_sel=4'b0100, alu_a=0, alu_b=0.
REQ-021 rst asserted mid-operation SHALL discard the in-flight command and all queued commands, with no response produced.
REQ-022 The ALU accumulator is not reset by this block except as given in REQ-024.

Configuration
REQ-023 Macro ALU_SEQ_CLR_ON_RESET_EN SHALL select the accumulator-clear feature.
REQ-024 With the macro defined: after rst deasserts, SHALL enter CLR, drive alu_sel=4'b0000, alu_a=0, alu_b=0 for one cycle, then WAIT-equivalent one cycle without response, then IDLE; cmd_ready=0 and busy=1 during CLR. Without it: reset goes directly to IDLE, and the accumulator is undefined until a non-accumulate op.

Structure
REQ-025 Package alu_seq_pkg SHALL hold the opcode enum (16 codes), the state enum, and the hold constants (HOLD_SEL=4'b0100).
REQ-026 SHALL instantiate sub-module alu_seq_fifo (parameter DEPTH, width 20, synchronous push/pop, full/empty).

Verification
REQ-027 ADD 5,3 (sel 0000) -> rsp_data=8, rsp_sel=0000, rsp_valid 3 cycles after the pop.
REQ-028 Sequence ADD 2,3; Acc+A A=4; Acc*A A=2 -> responses 5, 9, 18; with rsp_ready low 10 cycles between them, the results remain unchanged.
REQ-029 Push 6 commands with rsp_ready=0 -> cmd_ready drops after 5 accepted (4 queued + 1 in flight); responses arrive in order on release.
REQ-030 rst pulse during WAIT of CMP-EQ 7,7 -> no response; all outputs at reset values; the next ADD 1,1 gives 2.
REQ-031 Macro defined: reset, then Acc+A A=9 -> rsp_data=9; cmd_ready low for the CLR cycles.
